// File: rtl/sgpr_pkg.sv
// Shared SGPR read-path constants and types.
package sgpr_pkg;

  localparam int SGPR_ADDR_W   = 9;
  localparam int SGPR_DATA_W   = 32;
  localparam int SGPR_RD_PORTS = 8;
  localparam int SGPR_PTR_W    = 3;

  typedef logic [SGPR_ADDR_W-1:0] sgpr_addr_t;
  typedef logic [SGPR_DATA_W-1:0] sgpr_data_t;
  typedef logic [SGPR_PTR_W-1:0]  sgpr_ptr_t;

  // Next round-robin start position; wraps 7 -> 0 through the 3-bit width.
  function automatic sgpr_ptr_t rr_next(input sgpr_ptr_t idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/sgpr_rd_port_arbiter_if.sv
// Requester and mux-side signals of the SGPR read-port arbiter.
// master: requesters plus the SGPR mux model; slave: the arbiter.
interface sgpr_rd_port_arbiter_if;
  import sgpr_pkg::*;

  logic [SGPR_RD_PORTS-1:0]             req_vld;
  logic [SGPR_RD_PORTS*SGPR_ADDR_W-1:0] req_addr;
  logic [SGPR_RD_PORTS-1:0]             req_rdy;
  logic [SGPR_RD_PORTS-1:0]             mux_rd_en;
  logic [SGPR_RD_PORTS*SGPR_ADDR_W-1:0] mux_rd_addr;
  sgpr_data_t                           mux_rd_data;
  logic [SGPR_RD_PORTS-1:0]             rsp_vld;
  sgpr_data_t                           rsp_data;

  modport master (
    output req_vld, req_addr, mux_rd_data,
    input  req_rdy, mux_rd_en, mux_rd_addr, rsp_vld, rsp_data
  );

  modport slave (
    input  req_vld, req_addr, mux_rd_data,
    output req_rdy, mux_rd_en, mux_rd_addr, rsp_vld, rsp_data
  );

endinterface

// File: rtl/sgpr_rd_port_arbiter_rr.sv
// rr_arbiter_8: combinational rotate-priority picker. The scan starts at
// rr_ptr and the first set request wins, so grant is always one-hot or zero.
module rr_arbiter_8
  import sgpr_pkg::*;
(
  input  logic [7:0] pending,
  input  sgpr_ptr_t  rr_ptr,
  output logic [7:0] grant,
  output sgpr_ptr_t  gidx,
  output logic       any
);

  sgpr_ptr_t idx;

  // Walk the eight ports from rr_ptr and keep only the first hit.
  always_comb begin
    grant = '0;
    gidx  = rr_ptr;
    any   = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < 8; k++) begin
      idx = rr_ptr + k[2:0];
      if (!any && pending[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgpr_rd_port_arbiter.sv
// sgpr_rd_port_arbiter: one request slot per port, round-robin grant of one
// slot per cycle to the SGPR read mux, one-hot response tag a cycle later.
// Optional SGPR_RD_ARB_BYPASS_EN: when no slot is occupied, live requests
// compete directly and the winner goes to the mux without being stored.
module sgpr_rd_port_arbiter
  import sgpr_pkg::*;
#(
  parameter int NUM_PORTS  = SGPR_RD_PORTS,
  parameter int ADDR_WIDTH = SGPR_ADDR_W,
  parameter int DATA_WIDTH = SGPR_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  sgpr_rd_port_arbiter_if.slave bus
);

  logic [NUM_PORTS-1:0]            pending;
  logic [ADDR_WIDTH-1:0]           pend_addr [NUM_PORTS];
  sgpr_ptr_t                       rr_ptr;
  logic [NUM_PORTS-1:0]            rsp_vld_q;
  logic [NUM_PORTS-1:0]            arb_req;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_PORTS-1:0]            accept;
  logic [NUM_PORTS-1:0]            store;
  sgpr_ptr_t                       gidx;
  logic                            any;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0]           rd_data;

  assign accept      = bus.req_vld & ~pending;
  assign bus.req_rdy = ~pending;

`ifdef SGPR_RD_ARB_BYPASS_EN
  logic bypass;
  assign bypass  = ~|pending;
  assign arb_req = bypass ? bus.req_vld : pending;
  // The bypassed winner is consumed this cycle; only the losers take a slot.
  assign store   = bypass ? (accept & ~grant) : accept;
`else
  assign arb_req = pending;
  assign store   = accept;
`endif

  rr_arbiter_8 u_rr (
    .pending (arb_req),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .gidx    (gidx),
    .any     (any)
  );

  // Slot occupancy, rotation pointer and one-cycle response tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      rr_ptr    <= '0;
      rsp_vld_q <= '0;
    end else begin
      pending   <= (pending & ~grant) | store;
      rsp_vld_q <= grant;
      if (any) begin
        rr_ptr <= rr_next(gidx);
      end
    end
  end

  // Slot addresses need no reset; they are only read while pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (store[i]) begin
        pend_addr[i] <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Mux address per port: the slot, or the live request when bypassed.
  always_comb begin
    mux_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mux_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = pend_addr[i];
`ifdef SGPR_RD_ARB_BYPASS_EN
      if (bypass && grant[i]) begin
        mux_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
`endif
    end
  end

  assign rd_data         = bus.mux_rd_data;
  assign bus.mux_rd_en   = grant;
  assign bus.mux_rd_addr = mux_addr;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_data    = rd_data;

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// Scoreboard bench for sgpr_rd_port_arbiter. Stimulus pushes expected grants
// and responses; a negedge monitor pops and compares whenever the DUT shows
// a grant or a response, and also acts as the SGPR mux returning data.
module tb_sgpr_rd_port_arbiter;
  import sgpr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sgpr_rd_port_arbiter_if bus ();

  sgpr_rd_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] en;
    sgpr_addr_t addr;
  } grant_t;

  typedef struct {
    logic [7:0] vld;
    sgpr_data_t data;
  } rsp_t;

  grant_t     exp_grant [$];
  rsp_t       exp_rsp   [$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         rsp1_pulses = 0;
  logic [7:0] prev_en     = '0;

  function automatic sgpr_data_t sgpr_val(input sgpr_addr_t a);
    if (a == 9'h012) return 32'hDEADBEEF;
    return {16'hC0DE, 7'h00, a};
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input sgpr_addr_t a);
    bus.req_vld[p]          = 1'b1;
    bus.req_addr[p*9 +: 9]  = a;
  endtask

  task automatic expect_port(input int p, input sgpr_addr_t a);
    grant_t g;
    rsp_t   r;
    g.en      = '0;
    g.en[p]   = 1'b1;
    g.addr    = a;
    r.vld     = g.en;
    r.data    = sgpr_val(a);
    exp_grant.push_back(g);
    exp_rsp.push_back(r);
  endtask

  // Monitor and SGPR mux model.
  always @(negedge clk) begin
    grant_t g;
    rsp_t   r;
    if (rst) begin
      prev_en = '0;
    end else begin
      if (bus.rsp_vld != 8'h00 || prev_en != 8'h00) begin
        chk("rsp_follows_grant", 32'(bus.rsp_vld), 32'(prev_en));
      end
      if (bus.rsp_vld != 8'h00) begin
        if (bus.rsp_vld[1]) rsp1_pulses++;
        if (exp_rsp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got rsp_vld %0h, required none (t=%0t)", bus.rsp_vld, $time);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_vld", 32'(bus.rsp_vld), 32'(r.vld));
          chk("rsp_data", bus.rsp_data, r.data);
        end
      end
      if (bus.mux_rd_en != 8'h00) begin
        if (exp_grant.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: got mux_rd_en %0h, required none (t=%0t)", bus.mux_rd_en, $time);
        end else begin
          g = exp_grant.pop_front();
          chk("grant_en", 32'(bus.mux_rd_en), 32'(g.en));
          chk("grant_addr", 32'(bus.mux_rd_addr[onehot_idx(g.en)*9 +: 9]), 32'(g.addr));
        end
      end
      prev_en = bus.mux_rd_en;
    end
    if (bus.mux_rd_en != 8'h00)
      bus.mux_rd_data = sgpr_val(bus.mux_rd_addr[onehot_idx(bus.mux_rd_en)*9 +: 9]);
    else
      bus.mux_rd_data = '0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before t=100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.req_vld     = '0;
    bus.req_addr    = '0;
    bus.mux_rd_data = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Idle after reset.
    repeat (10) begin
      @(negedge clk);
      chk("idle_req_rdy", 32'(bus.req_rdy), 32'h0FF);
      chk("idle_mux_rd_en", 32'(bus.mux_rd_en), 32'h0);
      chk("idle_rsp_vld", 32'(bus.rsp_vld), 32'h0);
    end
    tick();

    // Single request on port 3, rr_ptr -> 4.
    set_req(3, 9'h012);
    expect_port(3, 9'h012);
`ifdef SGPR_RD_ARB_BYPASS_EN
    @(negedge clk);
    chk("p3_same_cycle_en", 32'(bus.mux_rd_en), 32'h08);
    tick();
    bus.req_vld = '0;
`else
    @(negedge clk);
    chk("p3_accept_cycle_en", 32'(bus.mux_rd_en), 32'h0);
    tick();
    bus.req_vld = '0;
    @(negedge clk);
    chk("p3_grant_en", 32'(bus.mux_rd_en), 32'h08);
    chk("p3_grant_addr", 32'(bus.mux_rd_addr[27 +: 9]), 32'h012);
    chk("p3_rdy_low", 32'(bus.req_rdy), 32'hF7);
    tick();
`endif
    @(negedge clk);
    chk("p3_rsp_vld", 32'(bus.rsp_vld), 32'h08);
    chk("p3_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    repeat (3) tick();

    // Ports 0,2,5,7 from rr_ptr=4: 5,7,0,2; rr_ptr -> 3.
    set_req(0, 9'h100);
    set_req(2, 9'h102);
    set_req(5, 9'h105);
    set_req(7, 9'h107);
    expect_port(5, 9'h105);
    expect_port(7, 9'h107);
    expect_port(0, 9'h100);
    expect_port(2, 9'h102);
    tick();
    bus.req_vld = '0;
    repeat (8) tick();

    // Port 1 holds a second request while its slot is busy; rr_ptr -> 2.
    rsp1_pulses = 0;
    set_req(1, 9'h011);
    expect_port(1, 9'h011);
    expect_port(1, 9'h0A1);
    tick();
    bus.req_addr[9 +: 9] = 9'h0A1;
`ifndef SGPR_RD_ARB_BYPASS_EN
    @(negedge clk);
    chk("p1_rdy_blocked", 32'(bus.req_rdy[1]), 32'h0);
    chk("p1_first_addr_kept", 32'(bus.mux_rd_addr[9 +: 9]), 32'h011);
`endif
    n = 0;
    while (n <= 20) begin
      @(negedge clk);
      if (bus.req_rdy[1]) break;
      n++;
    end
    chk("p1_rerequest_rdy_wait", 32'(n <= 20), 32'h1);
    tick();
    bus.req_vld = '0;
    repeat (6) tick();
    chk("p1_rsp_pulses", 32'(rsp1_pulses), 32'd2);

    // Reset with 4 slots busy and one grant in flight.
    set_req(2, 9'h0B2);
    set_req(3, 9'h0B3);
    set_req(4, 9'h0B4);
    set_req(5, 9'h0B5);
    set_req(6, 9'h0B6);
`ifdef SGPR_RD_ARB_BYPASS_EN
    rst = 1'b1;
    @(negedge clk);
    chk("rst_inflight_grant", 32'(bus.mux_rd_en), 32'h04);
    tick();
    bus.req_vld = '0;
    rst = 1'b0;
`else
    tick();
    bus.req_vld = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_inflight_grant", 32'(bus.mux_rd_en), 32'h04);
    tick();
    rst = 1'b0;
`endif
    @(negedge clk);
    chk("post_rst_req_rdy", 32'(bus.req_rdy), 32'h0FF);
    chk("post_rst_rsp_vld", 32'(bus.rsp_vld), 32'h0);
    chk("post_rst_mux_rd_en", 32'(bus.mux_rd_en), 32'h0);
    repeat (4) tick();
    // rr_ptr back at 0: port 1 before port 7; rr_ptr -> 0 via wrap.
    set_req(7, 9'h1C7);
    set_req(1, 9'h1C1);
    expect_port(1, 9'h1C1);
    expect_port(7, 9'h1C7);
    tick();
    bus.req_vld = '0;
    repeat (5) tick();

    // All eight ports from rr_ptr=0, served back to back.
    for (int p = 0; p < 8; p++) begin
      set_req(p, 9'(9'h040 + p));
      expect_port(p, 9'(9'h040 + p));
    end
    tick();
    bus.req_vld = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("burst_grant_busy", 32'(bus.mux_rd_en != 8'h00), 32'h1);
      tick();
    end
    repeat (4) tick();

    // Port 6 alone at 9'h1FF; rr_ptr -> 7.
    set_req(6, 9'h1FF);
    expect_port(6, 9'h1FF);
`ifdef SGPR_RD_ARB_BYPASS_EN
    @(negedge clk);
    chk("p6_bypass_en", 32'(bus.mux_rd_en), 32'h40);
    chk("p6_bypass_addr", 32'(bus.mux_rd_addr[54 +: 9]), 32'h1FF);
    tick();
    bus.req_vld = '0;
    @(negedge clk);
    chk("p6_not_stored", 32'(bus.req_rdy[6]), 32'h1);
    chk("p6_rsp_vld", 32'(bus.rsp_vld), 32'h40);
`else
    @(negedge clk);
    chk("p6_buffered_en", 32'(bus.mux_rd_en), 32'h0);
    tick();
    bus.req_vld = '0;
    @(negedge clk);
    chk("p6_grant_en", 32'(bus.mux_rd_en), 32'h40);
`endif
    repeat (3) tick();

    // From rr_ptr=7 the scan wraps: port 0 before port 6.
    set_req(6, 9'h0E6);
    set_req(0, 9'h0E0);
    expect_port(0, 9'h0E0);
    expect_port(6, 9'h0E6);
    tick();
    bus.req_vld = '0;
    repeat (5) tick();

    chk("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
